// File: rtl/tanh_lut_loader.sv
// Run-time loadable tanh lookup table: a valid/ready word stream fills the RAM
// from address 0, then registered one-cycle lookups are served from it.
module tanh_lut_loader #(
  parameter int AW = 10,
  parameter int DW = 16,
  parameter int N  = 16,
  parameter int Q  = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic          load_busy,
  output logic          load_done,
  output logic          table_ready,
  input  logic          lookup_valid,
  input  logic [N-1:0]  phase,
  output logic [DW-1:0] tanh,
  output logic          tanh_valid,
  output logic          lookup_drop
);

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  localparam logic [31:0] QBITS = Q;

  state_t        state, state_next;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] mem [2**AW];
  logic          accept;
  logic          last_word;
  logic          rd_en;
  logic          unused_bits;

  // Phase bits above the table index and the Q format are informational only.
  assign unused_bits = ^{phase[N-1:AW], QBITS[0]};

  assign accept    = wr_valid && (state == LOAD);
  assign last_word = accept && (wr_addr == {AW{1'b1}});
  assign rd_en     = lookup_valid && (state == READY);

  assign wr_ready    = (state == LOAD);
  assign load_busy   = (state == LOAD);
  assign table_ready = (state == READY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A load_start seen during LOAD is deliberately ignored.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (load_start) state_next = LOAD;
      LOAD:    if (last_word)  state_next = READY;
      READY:   if (load_start) state_next = LOAD;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr   <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= last_word;
      if (accept) begin
        wr_addr <= wr_addr + AW'(1);
      end else if ((state != LOAD) && (state_next == LOAD)) begin
        wr_addr <= '0;
      end
    end
  end

  // Write and read never coincide: writes happen only in LOAD, reads only in READY.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tanh        <= '0;
      tanh_valid  <= 1'b0;
      lookup_drop <= 1'b0;
    end else begin
      tanh_valid  <= rd_en;
      lookup_drop <= lookup_valid && (state != READY);
      if (rd_en) begin
        tanh <= mem[phase[AW-1:0]];
      end
    end
  end

endmodule
